// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared states, opcodes and select encodings for the multicycle controller
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   imm_sel = IMM_S;
      OP_BEQ:  imm_sel = IMM_B;
      OP_JAL:  imm_sel = IMM_J;
      default: imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - maps alu_op/funct fields to the ALU operation select
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) can encode sub; addi with funct7b5 set stays add
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM for a multicycle RV32 subset; MULTICYCLE_CTRL_TRAP_EN adds the illegal-op trap
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal
);

  state_t     state, next_state;
  logic       pc_update, branch;
  logic [1:0] alu_op;
`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic       illegal_c;
  assign illegal = illegal_c;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALUOP_ADD;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    illegal_c  = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        next_state = S_DECODE;
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURES;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTER;
          OP_ITYPE:     next_state = S_EXECUTEI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
`ifdef MULTICYCLE_CTRL_TRAP_EN
          default:      next_state = S_TRAP;
`else
          default:      next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
      end
      S_MEMREAD: begin
        next_state = S_MEMWB;
        adr_src    = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        next_state = S_ALUWB;
        alu_src_a  = SRC_A_RS1;
        alu_op     = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        next_state = S_ALUWB;
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        next_state = S_ALUWB;
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        pc_update  = 1'b1;
      end
      S_TRAP: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
        next_state = S_TRAP;
        illegal_c  = 1'b1;
`else
        next_state = S_FETCH;
`endif
      end
      default: next_state = S_FETCH;
    endcase

    // Reset wins over every state: enables off, selects parked at their FETCH values
    if (reset) begin
      next_state = S_FETCH;
      pc_update  = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_FOUR;
      result_src = RES_ALURES;
      alu_op     = ALUOP_ADD;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      illegal_c  = 1'b0;
`endif
    end
  end

  assign pc_write = pc_update | (branch & zero);
  assign imm_src  = imm_sel(op);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_control;

  int tests = 0;
  int fails = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AWB, P_BQ, P_J, P_TRAP, P_RST} ph_t;

  typedef struct packed {
    logic       ir, pcu, br, mw, rw, adr, ill;
    logic [1:0] a, b, aop, rs;
  } exp_t;

  ph_t seq[$];

  function automatic exp_t phase_out(ph_t p);
    exp_t e = '0;
    case (p)
      P_F:    begin e.ir = 1; e.pcu = 1; e.b = 2'b10; e.rs = 2'b10; end
      P_D:    begin e.a = 2'b01; e.b = 2'b01; end
      P_MA:   begin e.a = 2'b10; e.b = 2'b01; end
      P_MR:   begin e.adr = 1; end
      P_MWB:  begin e.rs = 2'b01; e.rw = 1; end
      P_MW:   begin e.adr = 1; e.mw = 1; end
      P_ER:   begin e.a = 2'b10; e.aop = 2'b10; end
      P_EI:   begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
      P_AWB:  begin e.rw = 1; end
      P_BQ:   begin e.a = 2'b10; e.aop = 2'b01; e.br = 1; end
      P_J:    begin e.a = 2'b01; e.b = 2'b10; e.pcu = 1; end
      P_TRAP: begin e.ill = 1; end
      P_RST:  begin e.b = 2'b10; e.rs = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] ref_alu(logic [1:0] aop, logic [2:0] f3, logic op5, logic f7);
    if (aop == 2'b01) return 3'b001;
    if (aop != 2'b10) return 3'b000;
    case (f3)
      3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] ref_imm(logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  task automatic build_seq(input logic [6:0] o);
    seq = {P_F, P_D};
    case (o)
      7'b0000011: seq = {seq, P_MA, P_MR, P_MWB};
      7'b0100011: seq = {seq, P_MA, P_MW};
      7'b0110011: seq = {seq, P_ER, P_AWB};
      7'b0010011: seq = {seq, P_EI, P_AWB};
      7'b1100011: seq = {seq, P_BQ};
      7'b1101111: seq = {seq, P_J, P_AWB};
      default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
        for (int i = 0; i < 10; i++) seq.push_back(P_TRAP);
`endif
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input ph_t p);
    exp_t e = phase_out(p);
    string s = p.name();
    check({"ir_write@", s},    {7'd0, ir_write},  {7'd0, e.ir});
    check({"pc_write@", s},    {7'd0, pc_write},  {7'd0, e.pcu | (e.br & zero)});
    check({"mem_write@", s},   {7'd0, mem_write}, {7'd0, e.mw});
    check({"reg_write@", s},   {7'd0, reg_write}, {7'd0, e.rw});
    check({"adr_src@", s},     {7'd0, adr_src},   {7'd0, e.adr});
    check({"illegal@", s},     {7'd0, illegal},   {7'd0, e.ill});
    check({"alu_src_a@", s},   {6'd0, alu_src_a}, {6'd0, e.a});
    check({"alu_src_b@", s},   {6'd0, alu_src_b}, {6'd0, e.b});
    check({"result_src@", s},  {6'd0, result_src}, {6'd0, e.rs});
    check({"imm_src@", s},     {6'd0, imm_src},   {6'd0, ref_imm(op)});
    check({"alu_control@", s}, {5'd0, alu_control}, {5'd0, ref_alu(e.aop, funct3, op[5], funct7b5)});
  endtask

  // zsel: 0/1 forces zero, 2 randomizes it; abort_k puts reset on that cycle of the instruction
  task automatic run_instr(input logic [6:0] op_i, input logic [2:0] f3_i, input logic f7_i,
                           input int zsel, input bit noise, input int abort_k);
    build_seq(op_i);
    for (int k = 0; k < seq.size(); k++) begin
      @(negedge clk);
      if (k == 1 || k == 2 || !noise) begin
        op = op_i; funct3 = f3_i; funct7b5 = f7_i;
      end else begin
        op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
      end
      zero = (zsel == 2) ? 1'($urandom) : 1'(zsel);
      if (k == abort_k) begin
        reset = 1'b1;
        #2 check_cycle(P_RST);
        return;
      end
      reset = 1'b0;
      #2 check_cycle(seq[k]);
    end
    if (seq[seq.size()-1] == P_TRAP) begin
      @(negedge clk);
      reset = 1'b1;
      #2 check_cycle(P_RST);
    end
  endtask

  initial begin
    logic [6:0] rop;
    int         ab;
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #2 check_cycle(P_RST);
    end

    run_instr(7'b0000011, 3'b010, 1'b0, 2, 1'b0, -1);
    run_instr(7'b0100011, 3'b010, 1'b0, 2, 1'b0, -1);
    run_instr(7'b0110011, 3'b000, 1'b1, 2, 1'b0, -1);
    run_instr(7'b0010011, 3'b000, 1'b1, 2, 1'b0, -1);
    run_instr(7'b1100011, 3'b000, 1'b0, 1, 1'b0, -1);
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 1'b0, -1);
    run_instr(7'b1101111, 3'b000, 1'b0, 2, 1'b0, -1);
    run_instr(7'b1111111, 3'b000, 1'b0, 2, 1'b0, -1);
    run_instr(7'b0100011, 3'b010, 1'b0, 2, 1'b0, 3);
    run_instr(7'b0000011, 3'b010, 1'b0, 2, 1'b0, -1);
    run_instr(7'b0110011, 3'b111, 1'b0, 2, 1'b1, -1);
    run_instr(7'b0110011, 3'b110, 1'b0, 2, 1'b1, -1);
    run_instr(7'b0110011, 3'b010, 1'b0, 2, 1'b1, -1);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 6))
        0: rop = 7'b0000011;
        1: rop = 7'b0100011;
        2: rop = 7'b0110011;
        3: rop = 7'b0010011;
        4: rop = 7'b1100011;
        5: rop = 7'b1101111;
        default: rop = 7'($urandom);
      endcase
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 13)) : -1;
      run_instr(rop, 3'($urandom), 1'($urandom), 2, 1'b1, ab);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-003 SHALL have input op, 7 bits: instruction opcode. SHALL have input funct3, 3 bits. SHALL have input funct7b5, 1 bit. SHALL have input zero, 1 bit: ALU zero flag.
REQ-004 SHALL have outputs pc_write, ir_write, mem_write, reg_write, adr_src: 1 bit each; write enables and memory-address select (0=PC, 1=result).
REQ-005 SHALL have outputs alu_src_a, 2 bits (00 PC, 01 OldPC, 10 rs1) and alu_src_b, 2 bits (00 rs2, 01 immExt, 10 const 4).
REQ-006 SHALL have output result_src, 2 bits (00 ALUOut, 01 read data, 10 ALU result).
REQ-007 SHALL have output imm_src, 2 bits (00 I, 01 S, 10 B, 11 J); this field is the select for the immediate extender.
REQ-008 SHALL have output alu_control, 3 bits (000 add, 001 sub, 010 and, 011 or, 101 slt). SHALL have output illegal, 1 bit.

Function
REQ-009 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, plus TRAP (REQ-020).
REQ-010 Transitions SHALL be: FETCH->DECODE. DECODE->MEMADR for op 0000011/0100011, EXECUTER for 0110011, EXECUTEI for 0010011, BEQ for 1100011, JAL for 1101111. MEMADR->MEMREAD for lw, MEMWRITE for sw. MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH. EXECUTER/EXECUTEI->ALUWB->FETCH. BEQ->FETCH. JAL->ALUWB.
REQ-011 Per-state outputs SHALL be as follows; unlisted outputs are 0.
- FETCH: ir_write=1, pc_update=1, a=00, b=10, alu_op=00, result_src=10.
- DECODE: a=01, b=01, alu_op=00.
- MEMADR: a=10, b=01, alu_op=00.
- MEMREAD: adr_src=1, result_src=00.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: adr_src=1, mem_write=1.
- EXECUTER: a=10, b=00, alu_op=10.
- EXECUTEI: a=10, b=01, alu_op=10.
- ALUWB: result_src=00, reg_write=1.
- BEQ: a=10, b=00, alu_op=01, branch=1.
- JAL: a=01, b=10, alu_op=00, pc_update=1.
REQ-012 pc_write SHALL equal pc_update OR (branch AND zero), evaluated combinationally in the same cycle.
REQ-013 imm_src SHALL be combinational from op in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, all other opcodes 00.
REQ-014 alu_control SHALL be decoded as follows.
- alu_op 00: add. alu_op 01: sub.
- alu_op 10, funct3 000: sub if op[5]&funct7b5, else add.
- alu_op 10, funct3 010: slt. 110: or. 111: and. Other funct3: add.
REQ-015 Instruction latency SHALL be: lw 5 cycles, sw 4, R/I-ALU 4, beq 3, jal 4, all counted from FETCH entry to the next FETCH entry.
REQ-016 op SHALL be sampled only when DECODE and MEMADR compute their next state; op changes in other states SHALL NOT alter the sequence.

Reset
REQ-017 While reset is high, the next state SHALL be FETCH at the following clk edge.
REQ-018 While reset is high, pc_write, ir_write, mem_write, reg_write and illegal SHALL be forced 0 combinationally; selects SHALL take their FETCH values.
REQ-019 Reset asserted mid-instruction SHALL abandon that instruction with no further write enable asserted.

Configuration
REQ-020 With macro MULTICYCLE_CTRL_TRAP_EN defined, an unrecognised op in DECODE SHALL go to TRAP. TRAP SHALL hold with illegal=1 and all write enables 0 until reset.
REQ-021 Without MULTICYCLE_CTRL_TRAP_EN, an unrecognised op in DECODE SHALL return to FETCH (acting as a nop), and illegal SHALL be tied 0.

Structure
REQ-022 A shared package SHALL hold the state enum, the opcode constants, and the imm_src, alu_src_a/b, result_src and alu_control encodings; the extender and datapath SHALL use the same package.
REQ-023 ALU decoding SHALL be one sub-module, alu_decoder, with inputs alu_op, funct3, op[5], funct7b5 and output alu_control.

Verification
REQ-024 Reset for 2 cycles, then release: state=FETCH, ir_write=1, pc_write=1, alu_src_b=10 in the first cycle after release.
REQ-025 op=0000011 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in cycle 5 with result_src=01; imm_src=00.
REQ-026 op=1100011, funct3=000, zero=1 in BEQ -> pc_write=1, alu_control=001, imm_src=10. Same with zero=0 -> pc_write=0. Both cases return to FETCH after 3 cycles.
REQ-027 op=0110011, funct3=000, funct7b5=1 -> alu_control=001 in EXECUTER, then reg_write=1 in ALUWB. op=0010011, funct3=000, funct7b5=1 -> alu_control=000.
REQ-028 op=1111111: with the macro defined, TRAP is entered and illegal=1 is held for 10 cycles until reset. Without the macro, FETCH is re-entered on the 3rd cycle.
REQ-029 Reset asserted in MEMWRITE -> mem_write=0 in that cycle, and state=FETCH on the next edge.
